hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_pkg.sv | 24 ++
 rtl/hamming_decoder_syndrome.sv | 17 +
 rtl/hamming_decoder.sv | 138 +++++++++++++
 tb/tb_hamming_decoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants for the Hamming(7,4) decoder: codeword bit positions,
// codeword/data/syndrome widths and the data-extraction helper.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Codeword bit positions; a parity bit sits at each power-of-two position
    // (1-based), so a nonzero syndrome is the 1-based index of the bad bit.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D0 = 2;
    localparam int P4 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    // Pull the data nibble {D3,D2,D1,D0} out of a codeword.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        return {code[D3], code[D2], code[D1], code[D0]};
    endfunction

endpackage

// File: rtl/hamming_decoder_syndrome.sv
// Purely combinational syndrome generator for a Hamming(7,4) codeword.
// Output is {S4,S2,S1}; zero means the codeword checks clean.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [SYN_W-1:0]  syndrome_o
);

    // Each check bit covers the positions whose 1-based index has that bit set.
    always_comb begin
        syndrome_o[0] = code_i[P1] ^ code_i[D0] ^ code_i[D1] ^ code_i[D3];
        syndrome_o[1] = code_i[P2] ^ code_i[D0] ^ code_i[D2] ^ code_i[D3];
        syndrome_o[2] = code_i[P4] ^ code_i[D1] ^ code_i[D2] ^ code_i[D3];
    end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(7,4) single-error-correcting decoder with valid/ready
// handshakes on both sides. Stage 1 captures the codeword and its syndrome;
// stage 2 flips the indicated bit and registers the data nibble.
// Optional feature: define HAMMING_ERR_CNT_EN to build the saturating
// corrected-word counter; otherwise corr_cnt is tied to zero.
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [SYN_W-1:0]    out_syndrome,
    output logic                out_corrected,
    output logic [CNT_W-1:0]    corr_cnt
);

    logic                s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0]   s1_code_q, s1_code_d;
    logic [SYN_W-1:0]    s1_syn_q, s1_syn_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SYN_W-1:0]    out_syn_q, out_syn_d;
    logic                out_corr_q, out_corr_d;

    logic [SYN_W-1:0]    in_syn;
    logic [CODE_W-1:0]   flip_mask;
    logic [CODE_W-1:0]   fixed_code;
    logic                s2_load;
    logic                in_fire;

    hamming_syndrome u_syndrome (
        .code_i     (in_code),
        .syndrome_o (in_syn)
    );

    // Stage 2 takes the stage-1 word whenever the output slot is free or draining.
    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    // Ready looks through to the output so a full pipe keeps streaming.
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = in_valid && in_ready;

    // One-hot flip mask: bit gi is inverted when the syndrome names position gi+1.
    genvar gi;
    generate
        for (gi = 0; gi < CODE_W; gi++) begin : g_flip
            assign flip_mask[gi] = (s1_syn_q == SYN_W'(gi + 1));
        end
    endgenerate

    assign fixed_code = s1_code_q ^ flip_mask;

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_corr_d  = out_corr_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_code_d  = in_code;
            s1_syn_d   = in_syn;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            out_data_d  = extract_data(fixed_code);
            out_syn_d   = s1_syn_q;
            out_corr_d  = |s1_syn_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset throws away anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_syn_q   <= '0;
            out_corr_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_corr_q  <= out_corr_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_syndrome  = out_syn_q;
    assign out_corrected = out_corr_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count each erroneous word once as it enters stage 2; stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_load && (|s1_syn_q) && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign corr_cnt = cnt_q;
`else
    assign corr_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed self-checking bench for hamming_decoder (CNT_W=2 so saturation
// is reachable). Counter expectations follow HAMMING_ERR_CNT_EN.
module tb_hamming_decoder;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_code;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [2:0]       out_syndrome;
    logic             out_corrected;
    logic [CNT_W-1:0] corr_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cnt      = 0;

    always #5 clk = ~clk;

    hamming_decoder #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_syndrome  (out_syndrome),
        .out_corrected (out_corrected),
        .corr_cnt      (corr_cnt)
    );

    // Reference encoder: builds a clean codeword from a data nibble.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Expected counter after one more erroneous word.
    function automatic int cnt_bump(input int c);
`ifdef HAMMING_ERR_CNT_EN
        return (c < CNT_MAX) ? c + 1 : c;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
        tick(); tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_data !== 4'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests_run++;
        if (out_syndrome !== 3'd0 || out_corrected !== 1'b0) begin
            tests_failed++; $display("FAIL reset_syn_corr got %0d/%b want 0/0", out_syndrome, out_corrected);
        end
        tests_run++;
        if (corr_cnt !== '0) begin tests_failed++; $display("FAIL reset_corr_cnt got %0d want 0", corr_cnt); end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        exp_cnt = 0;
        $display("[TB] reset: outputs cleared, in_ready=%b", in_ready);
    endtask

    task automatic test_known_vectors();
        logic [6:0] codes [3];
        logic [3:0] datas [3];
        logic [2:0] syns  [3];
        codes = '{7'h55, 7'h45, 7'h01};
        datas = '{4'b1011, 4'b1011, 4'b0000};
        syns  = '{3'd0, 3'd5, 3'd1};
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_code   = codes[i];
            tick();
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL latency_early code=%h out_valid got %b want 0", codes[i], out_valid);
            end
            tick();
            if (syns[i] != 3'd0) exp_cnt = cnt_bump(exp_cnt);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== datas[i] || out_syndrome !== syns[i] ||
                out_corrected !== (syns[i] != 3'd0)) begin
                tests_failed++;
                $display("FAIL vector code=%h got v=%b d=%b s=%0d c=%b want v=1 d=%b s=%0d c=%b",
                         codes[i], out_valid, out_data, out_syndrome, out_corrected,
                         datas[i], syns[i], syns[i] != 3'd0);
            end
            tests_run++;
            if (corr_cnt !== CNT_W'(exp_cnt)) begin
                tests_failed++; $display("FAIL vector_cnt code=%h got %0d want %0d", codes[i], corr_cnt, exp_cnt);
            end
            $display("[TB] vector code=%h data=%b syn=%0d corr=%b cnt=%0d",
                     codes[i], out_data, out_syndrome, out_corrected, corr_cnt);
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL vector_pop code=%h out_valid got %b want 0", codes[i], out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] code_t [10];
        logic [3:0] data_t [10];
        logic [2:0] syn_t  [10];
        logic [3:0] stall_data;
        logic [2:0] stall_syn;
        int sent = 0;
        int recv = 0;
        for (int i = 0; i < 10; i++) begin
            data_t[i] = 4'((i * 7 + 3) & 15);
            syn_t[i]  = 3'(i % 8);
            code_t[i] = encode(data_t[i]);
            if (syn_t[i] != 3'd0) code_t[i] = code_t[i] ^ (7'd1 << (syn_t[i] - 3'd1));
        end
        stall_data = '0;
        stall_syn  = '0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            in_valid  = (sent < 10);
            in_code   = (sent < 10) ? code_t[sent] : 7'h00;
            out_ready = !(cyc >= 5 && cyc < 8);
            #1;
            if (!out_ready) begin
                if (cyc > 5) begin
                    tests_run++;
                    if (out_data !== stall_data || out_syndrome !== stall_syn) begin
                        tests_failed++;
                        $display("FAIL stall_stable cyc=%0d got d=%b s=%0d want d=%b s=%0d",
                                 cyc, out_data, out_syndrome, stall_data, stall_syn);
                    end
                end
                if (cyc == 7) begin
                    tests_run++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL stall_full got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
                    end
                end
                stall_data = out_data;
                stall_syn  = out_syndrome;
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_data !== data_t[recv] || out_syndrome !== syn_t[recv] ||
                    out_corrected !== (syn_t[recv] != 3'd0)) begin
                    tests_failed++;
                    $display("FAIL b2b_word%0d got d=%b s=%0d c=%b want d=%b s=%0d c=%b", recv,
                             out_data, out_syndrome, out_corrected, data_t[recv], syn_t[recv], syn_t[recv] != 3'd0);
                end
                $display("[TB] b2b word %0d data=%b syn=%0d", recv, out_data, out_syndrome);
                if (syn_t[recv] != 3'd0) exp_cnt = cnt_bump(exp_cnt);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (recv != 10) begin tests_failed++; $display("FAIL b2b_count got %0d want 10", recv); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_dup out_valid got %b want 0", out_valid); end
        tests_run++;
        if (corr_cnt !== CNT_W'(exp_cnt)) begin
            tests_failed++; $display("FAIL b2b_cnt got %0d want %0d", corr_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_flight();
        bit leaked = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = encode(4'h5) ^ 7'b0000100;
        tick();
        in_code   = encode(4'hA) ^ 7'b0010000;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        exp_cnt = 0;
        tests_run++;
        if (out_valid !== 1'b0 || corr_cnt !== '0) begin
            tests_failed++; $display("FAIL midreset got out_valid=%b cnt=%0d want 0/0", out_valid, corr_cnt);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b0) leaked = 1'b1;
        end
        tests_run++;
        if (leaked) begin tests_failed++; $display("FAIL midreset_leak got out_valid=1 want 0"); end
        $display("[TB] mid-flight reset: out_valid=%b cnt=%0d", out_valid, corr_cnt);
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = encode(4'(i)) ^ (7'd1 << i);
            tick();
            exp_cnt = cnt_bump(exp_cnt);
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (corr_cnt !== CNT_W'(exp_cnt)) begin
            tests_failed++; $display("FAIL saturate got %0d want %0d", corr_cnt, exp_cnt);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL saturate_drain out_valid got %b want 0", out_valid); end
        $display("[TB] saturation: cnt=%0d", corr_cnt);
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_reset_mid_flight();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
